// File: rtl/regbank_pkg.sv
// regbank_pkg: shared types and constants for the
// register-bank arbiter slice.
package regbank_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IDX_W  = 3;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

endpackage

// File: rtl/regbank_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, onehot out.
// The requester that did not win last time has priority.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: shares one register bank between the
// core (req0) and the debug unit (req1), with bank lock.
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [IDX_W-1:0]  ri_a0,
  input  logic [IDX_W-1:0]  ri_b0,
  input  logic [IDX_W-1:0]  ri_d0,
  input  logic [IDX_W-1:0]  ri_a1,
  input  logic [IDX_W-1:0]  ri_b1,
  input  logic [IDX_W-1:0]  ri_d1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] b0,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] b1,
  output logic [IDX_W-1:0]  bank_ri_a,
  output logic [IDX_W-1:0]  bank_ri_b,
  output logic [IDX_W-1:0]  bank_ri_d,
  output logic              bank_rw,
  output logic [DATA_W-1:0] bank_d,
  input  logic [DATA_W-1:0] bank_a,
  input  logic [DATA_W-1:0] bank_b
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_last;
  logic               w_last_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_same;

  logic [1:0]         w_arb_req;
  logic [1:0]         w_pick;
  logic               w_any;
  logic               w_win;

  logic               w_lock;
  logic               w_rw;
  logic [IDX_W-1:0]   w_ri_a;
  logic [IDX_W-1:0]   w_ri_b;
  logic [IDX_W-1:0]   w_ri_d;
  logic [DATA_W-1:0]  w_d;

  logic               r_rv0;
  logic               r_rv1;
  logic [DATA_W-1:0]  r_a0;
  logic [DATA_W-1:0]  r_b0;
  logic [DATA_W-1:0]  r_a1;
  logic [DATA_W-1:0]  r_b1;

  // a live owner hides the other requester from the picker
  always_comb begin
    w_arb_req = {req1, req0};
    if (r_state == OWN0 && req0) w_arb_req = 2'b01;
    if (r_state == OWN1 && req1) w_arb_req = 2'b10;
  end

  rr_arb2 u_arb (
    .req  (w_arb_req),
    .last (r_last),
    .gnt  (w_pick)
  );

  assign w_any = |w_pick;
  assign w_win = w_pick[1];

  // route the winner's fields toward the bank
  always_comb begin
    w_lock = 1'b0;
    w_rw   = 1'b0;
    w_ri_a = '0;
    w_ri_b = '0;
    w_ri_d = '0;
    w_d    = '0;
    unique case (1'b1)
      w_pick[0]: begin
        w_lock = lock0;
        w_rw   = rw0;
        w_ri_a = ri_a0;
        w_ri_b = ri_b0;
        w_ri_d = ri_d0;
        w_d    = d0;
      end
      w_pick[1]: begin
        w_lock = lock1;
        w_rw   = rw1;
        w_ri_a = ri_a1;
        w_ri_b = ri_b1;
        w_ri_d = ri_d1;
        w_d    = d1;
      end
      default: ;
    endcase
  end

  // lock count restarts when ownership changes hands
  always_comb begin
    w_same = (r_state == OWN0 && w_pick[0])
          || (r_state == OWN1 && w_pick[1]);
    w_cnt_inc = w_same ? r_cnt + 1'b1 : CNT_W'(1);
  end

  // next ownership, lock count and round-robin history
  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_nxt   = '0;
    w_last_nxt  = r_last;
    if (w_any) begin
      w_last_nxt = w_win;
      if (w_lock && w_cnt_inc != CNT_W'(LOCK_MAX)) begin
        w_state_nxt = (w_win == REQ_DBG) ? OWN1 : OWN0;
        w_cnt_nxt   = w_cnt_inc;
      end
    end
  end

  // arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= REQ_DBG;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // capture read data for the granted reader
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rv0 <= 1'b0;
      r_rv1 <= 1'b0;
      r_a0  <= '0;
      r_b0  <= '0;
      r_a1  <= '0;
      r_b1  <= '0;
    end else begin
      r_rv0 <= w_pick[0] & ~w_rw;
      r_rv1 <= w_pick[1] & ~w_rw;
      if (w_pick[0] && !w_rw) begin
        r_a0 <= bank_a;
        r_b0 <= bank_b;
      end
      if (w_pick[1] && !w_rw) begin
        r_a1 <= bank_a;
        r_b1 <= bank_b;
      end
    end
  end

  assign gnt0      = rst_n & w_pick[0];
  assign gnt1      = rst_n & w_pick[1];
  assign bank_rw   = rst_n & w_any & w_rw;
  assign bank_ri_a = rst_n ? w_ri_a : '0;
  assign bank_ri_b = rst_n ? w_ri_b : '0;
  assign bank_ri_d = rst_n ? w_ri_d : '0;
  assign bank_d    = rst_n ? w_d : '0;

  assign rvalid0 = r_rv0;
  assign rvalid1 = r_rv1;
  assign a0      = r_a0;
  assign b0      = r_b0;
  assign a1      = r_a1;
  assign b1      = r_b1;

endmodule
